// File: rtl/decoding_round_driver_pkg.sv
// Shared definitions for the decoding-round driver and the host-side consumer.
// Holds the controller stage encoding, the driver FSM state encoding and the
// bit layout of a result record, so that producer and consumer decode res_data
// identically.
//
// Record layout, MSB first: {timeout, iterations, cycles, round_id}
package decoding_round_driver_pkg;

  // Controller stage encoding (shared with the unified stage controller).
  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE   = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_DECODE = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE  = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_UPDATE = 3'd3;

  localparam int CYCLE_COUNTER_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_PUSH      = 3'd4,
    S_RECOVER   = 3'd5
  } drv_state_t;

  // Field offsets within a record, given the parameterised field widths.
  function automatic int rec_round_id_lsb();
    return 0;
  endfunction

  function automatic int rec_cycles_lsb(input int round_id_width);
    return round_id_width;
  endfunction

  function automatic int rec_iterations_lsb(input int round_id_width);
    return round_id_width + CYCLE_COUNTER_WIDTH;
  endfunction

  function automatic int rec_timeout_bit(input int round_id_width, input int iter_width);
    return round_id_width + CYCLE_COUNTER_WIDTH + iter_width;
  endfunction

  function automatic int rec_width(input int round_id_width, input int iter_width);
    return round_id_width + CYCLE_COUNTER_WIDTH + iter_width + 1;
  endfunction

endpackage

// File: rtl/decoding_round_driver_result_fifo.sv
// result_fifo: synchronous FIFO holding result records, with occupancy count.
// The head entry is presented combinationally; data reads as zero when empty.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_push, i_data  write one entry (ignored when full unless a pop coincides)
//   i_pop           remove the head entry (ignored when empty)
//   o_valid         head entry present
//   o_data          head entry, zero when empty
//   o_count         number of stored entries
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL_COUNT) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/decoding_round_driver.sv
// decoding_round_driver: host-side initiator for the decoding-round
// start/result interface. Accepts a round request, pulses new_round_start,
// follows global_stage/result_valid until the round completes (or the
// watchdog expires) and queues one result record per round.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high; valid never depends on ready.
//   round_req_valid/round_req_ready : host -> driver round request
//   res_valid/res_ready             : driver -> host result record
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   round_req_valid / round_req_ready   round request handshake
//   new_round_start                     one-cycle start pulse to the controller
//   global_stage, result_valid          controller stage and done flag
//   iteration_counter, cycle_counter    controller counters captured at round end
//   res_valid / res_ready / res_data    result record handshake
//   fifo_count                          result FIFO occupancy
//   o_dbg_state                         current driver FSM state
module decoding_round_driver
  import decoding_round_driver_pkg::*;
#(
  parameter int          ITERATION_COUNTER_WIDTH = 8,
  parameter int          ROUND_ID_WIDTH          = 8,
  parameter int          FIFO_DEPTH              = 4,
  parameter logic [31:0] TIMEOUT_CYCLES          = 32'd65535,
  localparam int REC_W = rec_width(ROUND_ID_WIDTH, ITERATION_COUNTER_WIDTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               round_req_valid,
  output logic                               round_req_ready,
  output logic                               new_round_start,
  input  logic [STAGE_WIDTH-1:0]             global_stage,
  input  logic                               result_valid,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  input  logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [REC_W-1:0]                   res_data,
  output logic [CNT_W-1:0]                   fifo_count,
  output drv_state_t                         o_dbg_state
);

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  drv_state_t                         r_state;
  drv_state_t                         w_state_next;
  logic                               r_ready_en;
  logic                               r_new_round_start;
  logic [31:0]                        r_watchdog;
  logic                               r_timeout;
  logic                               r_recover;
  logic [ITERATION_COUNTER_WIDTH-1:0] r_iterations;
  logic [CYCLE_COUNTER_WIDTH-1:0]     r_cycles;
  logic [ROUND_ID_WIDTH-1:0]          r_round_id;

  logic             w_stage_idle;
  logic             w_done;
  logic             w_wd_hit;
  logic             w_accept;
  logic             w_capture;
  logic             w_capture_timeout;
  logic             w_push;
  logic [REC_W-1:0] w_record;

  assign w_stage_idle = (global_stage == STAGE_IDLE);
  assign w_done       = w_stage_idle && result_valid;
  // r_watchdog counts the wait cycles already finished; +1 includes the
  // current one, so the limit is reached on the TIMEOUT_CYCLES-th wait cycle.
  assign w_wd_hit     = ((r_watchdog + 32'd1) == TIMEOUT_CYCLES);

  // r_ready_en holds ready low for the first cycle out of reset.
  assign round_req_ready = (r_state == S_IDLE) && r_ready_en && w_stage_idle &&
                           (fifo_count != FIFO_FULL);
  assign w_accept        = round_req_valid && round_req_ready;

  assign new_round_start = r_new_round_start;
  assign o_dbg_state     = r_state;
  assign w_record        = {r_timeout, r_iterations, r_cycles, r_round_id};

  always_comb begin
    w_state_next      = r_state;
    w_capture         = 1'b0;
    w_capture_timeout = 1'b0;
    w_push            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_START;
      end
      S_START: begin
        w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A result_valid seen here is stale from the previous round.
        if (w_wd_hit) begin
          w_capture         = 1'b1;
          w_capture_timeout = 1'b1;
          w_state_next      = S_PUSH;
        end else if (!w_stage_idle) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Completion takes priority over a coincident watchdog expiry.
        if (w_done) begin
          w_capture    = 1'b1;
          w_state_next = S_PUSH;
        end else if (w_wd_hit) begin
          w_capture         = 1'b1;
          w_capture_timeout = 1'b1;
          w_state_next      = S_PUSH;
        end
      end
      S_PUSH: begin
        // A slot was reserved at accept time, so this write cannot be lost.
        w_push       = 1'b1;
        w_state_next = r_recover ? S_RECOVER : S_IDLE;
      end
      S_RECOVER: begin
        // The abandoned round's late result is dropped here.
        if (w_stage_idle) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_ready_en        <= 1'b0;
      r_new_round_start <= 1'b0;
      r_watchdog        <= '0;
      r_timeout         <= 1'b0;
      r_recover         <= 1'b0;
      r_iterations      <= '0;
      r_cycles          <= '0;
      r_round_id        <= '0;
    end else begin
      r_state           <= w_state_next;
      r_ready_en        <= 1'b1;
      r_new_round_start <= (w_state_next == S_START);

      if (r_state == S_START) begin
        r_watchdog <= '0;
      end else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE)) begin
        r_watchdog <= r_watchdog + 32'd1;
      end

      if (w_capture) begin
        r_timeout    <= w_capture_timeout;
        r_recover    <= w_capture_timeout && !w_stage_idle;
        r_iterations <= iteration_counter;
        r_cycles     <= cycle_counter;
      end

      if (w_push) r_round_id <= r_round_id + ROUND_ID_WIDTH'(1);
    end
  end

  result_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_record),
    .i_pop   (res_ready),
    .o_valid (res_valid),
    .o_data  (res_data),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_decoding_round_driver.sv
module tb_decoding_round_driver;
  import decoding_round_driver_pkg::*;

  localparam int TO    = 30;
  localparam int REC_W = 49;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              round_req_valid;
  logic              round_req_ready;
  logic              new_round_start;
  logic [2:0]        global_stage;
  logic              result_valid;
  logic [7:0]        iteration_counter;
  logic [31:0]       cycle_counter;
  logic              res_valid;
  logic              res_ready;
  logic [REC_W-1:0]  res_data;
  logic [2:0]        fifo_count;
  drv_state_t        o_dbg_state;

  decoding_round_driver #(
    .ITERATION_COUNTER_WIDTH(8),
    .ROUND_ID_WIDTH(8),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(32'd30)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .round_req_valid   (round_req_valid),
    .round_req_ready   (round_req_ready),
    .new_round_start   (new_round_start),
    .global_stage      (global_stage),
    .result_valid      (result_valid),
    .iteration_counter (iteration_counter),
    .cycle_counter     (cycle_counter),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .fifo_count        (fifo_count),
    .o_dbg_state       (o_dbg_state)
  );

  // scoreboard
  logic [REC_W-1:0] exp_q[$];
  logic [7:0]       exp_rid;
  int               n_checks;
  int               n_errors;

  // Raise a request and wait (bounded) for acceptance. Returns at the
  // negedge of the cycle in which new_round_start should be high (j=1).
  task automatic start_round(output bit ok);
    int waited;
    waited = 0;
    round_req_valid = 1'b1;
    #1;
    while (round_req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_checks++;
    ok = (round_req_ready === 1'b1);
    if (!ok) begin
      n_errors++;
      $display("FAIL accept: round_req_ready=%b after %0d cycles, required 1", round_req_ready, waited);
    end
    @(negedge clk);
    round_req_valid = 1'b0;
  endtask

  // Controller model for one normal round: leaves IDLE after edge N+2,
  // completes at j=c (c = busy+3). The record becomes visible at j=c+2.
  task automatic run_round(input int busy, input logic [7:0] iters, input logic [31:0] cycs,
                           input bit pop_at_push, output bit ok, output int n_start,
                           output int first_start, output logic [2:0] cnt_before);
    int c;
    c = busy + 3;
    n_start = 0;
    first_start = 0;
    cnt_before = '0;
    start_round(ok);
    if (ok) begin
      for (int j = 1; j <= c + 2; j++) begin
        if (j > 1) @(negedge clk);
        if (new_round_start === 1'b1) begin
          n_start++;
          if (first_start == 0) first_start = j;
        end
        if (j == 3) begin
          global_stage = STAGE_DECODE;
          result_valid = 1'b0;
        end
        if (j == c) begin
          global_stage      = STAGE_IDLE;
          result_valid      = 1'b1;
          iteration_counter = iters;
          cycle_counter     = cycs;
        end
        if (j == c + 1) begin
          cnt_before = fifo_count;
          if (pop_at_push) res_ready = 1'b1;
        end
      end
      res_ready = 1'b0;
      exp_q.push_back({1'b0, iters, cycs, exp_rid});
      exp_rid++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    round_req_valid = 1'b0;
    global_stage = STAGE_IDLE;
    result_valid = 1'b0;
    iteration_counter = '0;
    cycle_counter = '0;
    res_ready = 1'b0;
    exp_rid = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
    n_checks++; if (res_data !== '0) begin n_errors++; $display("FAIL reset_res_data: got %h, required 0", res_data); end
    n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count); end
    n_checks++; if (new_round_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b, required 0", new_round_start); end
    n_checks++; if (o_dbg_state !== S_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d, required %0d", o_dbg_state, S_IDLE); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (round_req_ready !== 1'b0) begin n_errors++; $display("FAIL ready_first_cycle: got %b, required 0", round_req_ready); end
    @(negedge clk);
    n_checks++; if (round_req_ready !== 1'b1) begin n_errors++; $display("FAIL ready_after_reset: got %b, required 1", round_req_ready); end
  endtask

  task automatic test_single_round();
    bit ok; int ns; int fs; logic [2:0] cb;
    run_round(17, 8'd3, 32'd20, 1'b0, ok, ns, fs, cb);
    n_checks++; if (ns != 1) begin n_errors++; $display("FAIL start_pulse_count: got %0d, required 1", ns); end
    n_checks++; if (fs != 1) begin n_errors++; $display("FAIL start_pulse_cycle: got %0d, required 1", fs); end
    n_checks++; if (cb !== 3'd0) begin n_errors++; $display("FAIL count_before_push: got %0d, required 0", cb); end
    n_checks++; if (res_valid !== 1'b1) begin n_errors++; $display("FAIL single_res_valid: got %b, required 1", res_valid); end
    n_checks++; if (res_data !== {1'b0, 8'd3, 32'd20, 8'd0}) begin n_errors++; $display("FAIL single_record: got %h, required %h", res_data, {1'b0, 8'd3, 32'd20, 8'd0}); end
    void'(exp_q.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL single_after_pop: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    bit ok; int ns; int fs; logic [2:0] cb; int stalled;
    for (int k = 0; k < 4; k++) run_round(2, 8'(10 + k), 32'(200 + k), 1'b0, ok, ns, fs, cb);
    n_checks++; if (fifo_count !== 3'd4) begin n_errors++; $display("FAIL b2b_full_count: got %0d, required 4", fifo_count); end
    round_req_valid = 1'b1;
    stalled = 0;
    repeat (6) begin
      @(negedge clk);
      if (round_req_ready === 1'b0) stalled++;
    end
    n_checks++; if (stalled != 6) begin n_errors++; $display("FAIL b2b_stall: ready low in %0d of 6 cycles, required 6", stalled); end
    n_checks++; if (o_dbg_state !== S_IDLE) begin n_errors++; $display("FAIL b2b_no_accept: state %0d, required %0d", o_dbg_state, S_IDLE); end
    round_req_valid = 1'b0;
    n_checks++; if (res_data !== exp_q[0]) begin n_errors++; $display("FAIL b2b_head: got %h, required %h", res_data, exp_q[0]); end
    void'(exp_q.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++; if (round_req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_after_pop: got %b, required 1", round_req_ready); end
    run_round(2, 8'd14, 32'd204, 1'b0, ok, ns, fs, cb);
    n_checks++; if (fifo_count !== 3'd4) begin n_errors++; $display("FAIL b2b_refill: got %0d, required 4", fifo_count); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (res_data !== exp_q[0]) begin n_errors++; $display("FAIL b2b_drain%0d: got %h, required %h", k, res_data, exp_q[0]); end
      void'(exp_q.pop_front());
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL b2b_empty: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_timeout_idle();
    bit ok;
    logic [REC_W-1:0] exp_rec;
    iteration_counter = 8'd7;
    cycle_counter = 32'h55;
    result_valid = 1'b0;
    global_stage = STAGE_IDLE;
    exp_rec = {1'b1, 8'd7, 32'h55, exp_rid};
    start_round(ok);
    if (ok) begin
      for (int j = 1; j <= TO + 3; j++) begin
        if (j > 1) @(negedge clk);
        if (j == TO + 2) begin
          n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL to_early_push: count %0d, required 0", fifo_count); end
          n_checks++; if (o_dbg_state !== S_PUSH) begin n_errors++; $display("FAIL to_push_state: got %0d, required %0d", o_dbg_state, S_PUSH); end
        end
        if (j == TO + 3) begin
          n_checks++; if (fifo_count !== 3'd1) begin n_errors++; $display("FAIL to_pushed: count %0d, required 1", fifo_count); end
          n_checks++; if (res_data !== exp_rec) begin n_errors++; $display("FAIL to_record: got %h, required %h", res_data, exp_rec); end
          n_checks++; if (o_dbg_state !== S_IDLE) begin n_errors++; $display("FAIL to_back_idle: got %0d, required %0d", o_dbg_state, S_IDLE); end
          n_checks++; if (round_req_ready !== 1'b1) begin n_errors++; $display("FAIL to_ready: got %b, required 1", round_req_ready); end
        end
      end
      exp_rid++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_timeout_recover();
    bit ok;
    logic [REC_W-1:0] exp_rec;
    iteration_counter = 8'd7;
    cycle_counter = 32'h66;
    result_valid = 1'b0;
    global_stage = STAGE_IDLE;
    exp_rec = {1'b1, 8'd7, 32'h66, exp_rid};
    start_round(ok);
    if (ok) begin
      for (int j = 1; j <= 45; j++) begin
        if (j > 1) @(negedge clk);
        if (j == 3) global_stage = STAGE_MERGE;
        if (j == TO + 3) begin
          n_checks++; if (fifo_count !== 3'd1) begin n_errors++; $display("FAIL rec_pushed: count %0d, required 1", fifo_count); end
          n_checks++; if (res_data !== exp_rec) begin n_errors++; $display("FAIL rec_record: got %h, required %h", res_data, exp_rec); end
          n_checks++; if (o_dbg_state !== S_RECOVER) begin n_errors++; $display("FAIL rec_state: got %0d, required %0d", o_dbg_state, S_RECOVER); end
        end
        if (j == 40) begin
          n_checks++; if (round_req_ready !== 1'b0) begin n_errors++; $display("FAIL rec_ready_held: got %b, required 0", round_req_ready); end
          global_stage = STAGE_IDLE;
          result_valid = 1'b1;
          iteration_counter = 8'd9;
          cycle_counter = 32'd999;
        end
        if (j == 41) begin
          n_checks++; if (o_dbg_state !== S_IDLE) begin n_errors++; $display("FAIL rec_idle: got %0d, required %0d", o_dbg_state, S_IDLE); end
          n_checks++; if (round_req_ready !== 1'b1) begin n_errors++; $display("FAIL rec_ready_back: got %b, required 1", round_req_ready); end
        end
        if (j == 45) begin
          n_checks++; if (fifo_count !== 3'd1) begin n_errors++; $display("FAIL rec_late_dropped: count %0d, required 1", fifo_count); end
        end
      end
      exp_rid++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_push_pop_same_cycle();
    bit ok; int ns; int fs; logic [2:0] cb;
    run_round(2, 8'd21, 32'd31, 1'b0, ok, ns, fs, cb);
    run_round(2, 8'd22, 32'd32, 1'b1, ok, ns, fs, cb);
    void'(exp_q.pop_front());
    n_checks++; if (cb !== 3'd1) begin n_errors++; $display("FAIL pp_before: count %0d, required 1", cb); end
    n_checks++; if (fifo_count !== 3'd1) begin n_errors++; $display("FAIL pp_count: got %0d, required 1", fifo_count); end
    n_checks++; if (res_data !== exp_q[0]) begin n_errors++; $display("FAIL pp_head: got %h, required %h", res_data, exp_q[0]); end
    void'(exp_q.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    bit ok; int ns; int fs; logic [2:0] cb;
    run_round(2, 8'd5, 32'd55, 1'b0, ok, ns, fs, cb);
    start_round(ok);
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      if (j == 3) begin
        global_stage = STAGE_DECODE;
        result_valid = 1'b0;
      end
    end
    n_checks++; if (o_dbg_state !== S_WAIT_DONE) begin n_errors++; $display("FAIL mid_state: got %0d, required %0d", o_dbg_state, S_WAIT_DONE); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL mid_fifo_count: got %0d, required 0", fifo_count); end
    n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL mid_res_valid: got %b, required 0", res_valid); end
    n_checks++; if (res_data !== '0) begin n_errors++; $display("FAIL mid_res_data: got %h, required 0", res_data); end
    n_checks++; if (o_dbg_state !== S_IDLE) begin n_errors++; $display("FAIL mid_state_idle: got %0d, required %0d", o_dbg_state, S_IDLE); end
    n_checks++; if (round_req_ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready: got %b, required 0", round_req_ready); end
    exp_q.delete();
    exp_rid = '0;
    global_stage = STAGE_IDLE;
    result_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    run_round(2, 8'd4, 32'd44, 1'b0, ok, ns, fs, cb);
    n_checks++; if (res_data !== {1'b0, 8'd4, 32'd44, 8'd0}) begin n_errors++; $display("FAIL mid_next_round: got %h, required %h", res_data, {1'b0, 8'd4, 32'd44, 8'd0}); end
    void'(exp_q.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_round_id_wrap();
    bit ok; int ns; int fs; logic [2:0] cb;
    int bad;
    bad = 0;
    // Start from round_id 0 after a reset so the sequence is 0..255 then 0.
    reset = 1'b1;
    exp_q.delete();
    exp_rid = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 257; k++) begin
      run_round(1, 8'(k), 32'(k * 3), 1'b0, ok, ns, fs, cb);
      n_checks++;
      if (res_data !== exp_q[0]) begin
        n_errors++;
        bad++;
        if (bad < 5) $display("FAIL wrap_record%0d: got %h, required %h", k, res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    n_checks++; if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL wrap_empty: got %0d, required 0", fifo_count); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_single_round();
    test_back_to_back();
    test_timeout_idle();
    test_timeout_recover();
    test_push_pop_same_cycle();
    test_reset_mid_round();
    test_round_id_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
